// File: rtl/seg7_pkg.sv
// Shared constants, state type and glyph table for the 7-segment scan controller.
// Optional feature: SEG7_LEADING_ZERO_BLANK_EN (see seg7_scan_controller.sv).
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    typedef enum logic {IDLE, SCAN} scan_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    // Active-low {dp,g,f,e,d,c,b,a}; dp kept off in every glyph.
    localparam logic [7:0] GLYPH_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,   // 0 1 2 3
        8'h99, 8'h92, 8'h82, 8'hF8,   // 4 5 6 7
        8'h80, 8'h90, 8'h88, 8'h83,   // 8 9 A b
        8'hC6, 8'hA1, 8'h86, 8'h8E    // C d E F
    };

    // True when digit idx sits above the most significant nonzero nibble.
    // Digit 0 is never blanked so a zero value still shows a single '0'.
    function automatic logic digit_is_leading_zero(input logic [15:0] val,
                                                   input logic [IDX_W-1:0] idx);
        logic r;
        unique case (idx)
            2'd0:    r = 1'b0;
            2'd1:    r = (val[15:4] == 12'h000);
            2'd2:    r = (val[15:8] == 8'h00);
            default: r = (val[15:12] == 4'h0);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble-to-segment lookup (active-low, dp off).
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    // Table lookup of the board's hex glyphs.
    always_comb begin
        o_seg = GLYPH_TABLE[i_nibble];
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Values arrive through a valid/ready handshake into a shadow register and are
// committed to the displayed register only at frame boundaries (or while idle),
// so a frame never mixes two values.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading-zero digits.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned PRESC_W     = 17
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [15:0] i_value_in,
    input  logic        i_load_valid,
    output logic        o_load_ready,
    output logic [7:0]  o_seg,
    output logic [3:0]  o_anode,
    output logic        o_frame_done
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t        r_state, w_state_next;
    logic [PRESC_W-1:0] r_presc, w_presc_next;
    logic [IDX_W-1:0]   r_idx, w_idx_next;
    logic [15:0]        r_disp;
    logic [15:0]        r_shadow;
    logic               r_pending, w_pending_next;
    logic [7:0]         r_seg, w_seg_next;
    logic [3:0]         r_anode, w_anode_next;
    logic               r_frame_done, w_frame_done_next;

    logic               w_tick;
    logic               w_accept;
    logic               w_commit;
    logic [15:0]        w_src;
    logic [IDX_W-1:0]   w_dec_idx;
    logic [3:0]         w_nibble;
    logic [7:0]         w_dec_seg;
    logic [7:0]         w_glyph;

    assign w_tick   = (r_state == SCAN) && (r_presc == PRESC_LAST);
    // Accept needs pending=0 and commit needs pending=1, so they never share an edge.
    assign w_accept = i_load_valid && !r_pending;
    assign w_commit = r_pending &&
                      ((r_state == IDLE) || (w_tick && i_enable && (r_idx == IDX_LAST)));

    // Digit 0 of a new frame already uses the value committed on the same edge.
    assign w_src     = w_commit ? r_shadow : r_disp;
    assign w_dec_idx = (r_state == SCAN) ? r_idx + IDX_W'(1) : '0;

    // Select the nibble for the digit being loaded into the output registers.
    always_comb begin
        w_nibble = w_src[3:0];
        unique case (w_dec_idx)
            2'd0:    w_nibble = w_src[3:0];
            2'd1:    w_nibble = w_src[7:4];
            2'd2:    w_nibble = w_src[11:8];
            default: w_nibble = w_src[15:12];
        endcase
    end

    seg7_hex_decoder u_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign w_glyph = digit_is_leading_zero(w_src, w_dec_idx) ? SEG_BLANK : w_dec_seg;
`else
    assign w_glyph = w_dec_seg;
`endif

    // Next-state and registered-output logic of the scan FSM.
    always_comb begin
        w_state_next      = r_state;
        w_presc_next      = r_presc;
        w_idx_next        = r_idx;
        w_seg_next        = r_seg;
        w_anode_next      = r_anode;
        w_frame_done_next = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_presc_next = '0;
                w_idx_next   = '0;
                w_seg_next   = SEG_BLANK;
                w_anode_next = ANODE_OFF;
                if (i_enable) begin
                    w_state_next = SCAN;
                    w_anode_next = 4'b1110;
                    w_seg_next   = w_glyph;
                end
            end
            SCAN: begin
                if (!i_enable) begin
                    w_state_next = IDLE;
                    w_presc_next = '0;
                    w_idx_next   = '0;
                    w_seg_next   = SEG_BLANK;
                    w_anode_next = ANODE_OFF;
                end else if (w_tick) begin
                    w_presc_next      = '0;
                    w_idx_next        = w_dec_idx;
                    w_anode_next      = ~(4'b0001 << w_dec_idx);
                    w_seg_next        = w_glyph;
                    w_frame_done_next = (r_idx == IDX_LAST);
                end else begin
                    w_presc_next = r_presc + PRESC_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Pending flag: set on accept, cleared on commit.
    always_comb begin
        w_pending_next = r_pending;
        if (w_accept) begin
            w_pending_next = 1'b1;
        end else if (w_commit) begin
            w_pending_next = 1'b0;
        end
    end

    // FSM, counters and output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_presc      <= '0;
            r_idx        <= '0;
            r_seg        <= SEG_BLANK;
            r_anode      <= ANODE_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_presc      <= w_presc_next;
            r_idx        <= w_idx_next;
            r_seg        <= w_seg_next;
            r_anode      <= w_anode_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    // Shadow/pending handshake and displayed-value register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shadow  <= 16'h0000;
            r_pending <= 1'b0;
            r_disp    <= 16'h0000;
        end else begin
            r_pending <= w_pending_next;
            if (w_accept) begin
                r_shadow <= i_value_in;
            end
            if (w_commit) begin
                r_disp <= r_shadow;
            end
        end
    end

    assign o_load_ready = ~r_pending;
    assign o_seg        = r_seg;
    assign o_anode      = r_anode;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed self-checking bench for seg7_scan_controller with REFRESH_DIV=4.
// Honours SEG7_LEADING_ZERO_BLANK_EN in its expected segment values.
module tb_seg7_scan_controller;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] value_in;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  seg;
    logic [3:0]  anode;
    logic        frame_done;

    int n_cmp  = 0;
    int n_fail = 0;
    int c      = 0;

    seg7_scan_controller #(
        .REFRESH_DIV (4),
        .PRESC_W     (2)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_enable     (enable),
        .i_value_in   (value_in),
        .i_load_valid (load_valid),
        .o_load_ready (load_ready),
        .o_seg        (seg),
        .o_anode      (anode),
        .o_frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] glyph(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
            4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
            4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
            4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
        endcase
        return g;
    endfunction

    function automatic logic [7:0] exp_seg(input logic [15:0] val, input int idx);
        logic [15:0] upper;
        upper = val >> (4 * idx);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (idx > 0 && upper == 16'h0000) return 8'hFF;
`endif
        return glyph(upper[3:0]);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (c=%0d)", tag, obs, expv, c);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance one clock while scanning and check the slot for edge count c.
    task automatic adv_chk(input logic [15:0] val);
        int         idx;
        logic [3:0] exp_an;
        step();
        c++;
        idx    = (c / 4) % 4;
        exp_an = ~(4'b0001 << idx);
        check("anode", 16'(anode), 16'(exp_an));
        check("seg", 16'(seg), 16'(exp_seg(val, idx)));
        check("frame_done", 16'(frame_done), (c % 16 == 0) ? 16'd1 : 16'd0);
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        value_in   = 16'h0000;
        load_valid = 1'b0;

        // Reset low-high-low with enable=0.
        #2 reset = 1'b1;
        #10;
        check("rst_seg", 16'(seg), 16'h00FF);
        check("rst_anode", 16'(anode), 16'h000F);
        check("rst_ready", 16'(load_ready), 16'd1);
        check("rst_fd", 16'(frame_done), 16'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) begin
            step();
            check("idle_fd", 16'(frame_done), 16'd0);
            check("idle_anode", 16'(anode), 16'h000F);
            check("idle_seg", 16'(seg), 16'h00FF);
        end

        // Load while idle: accepted, then committed on the next edge.
        value_in   = 16'h12AF;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        value_in   = 16'h0000;
        check("idle_accept_ready", 16'(load_ready), 16'd0);
        step();
        check("idle_commit_ready", 16'(load_ready), 16'd1);
        check("idle_still_blank", 16'(anode), 16'h000F);

        // Enable: first edge lights digit 0.
        enable = 1'b1;
        step();
        c = 0;
        check("e0_anode", 16'(anode), 16'h000E);
        check("e0_seg", 16'(seg), 16'(exp_seg(16'h12AF, 0)));
        check("e0_fd", 16'(frame_done), 16'd0);
        repeat (16) adv_chk(16'h12AF);
        repeat (5) adv_chk(16'h12AF);

        // Mid-frame load; a second load while pending is ignored.
        value_in   = 16'h3456;
        load_valid = 1'b1;
        adv_chk(16'h12AF);
        load_valid = 1'b0;
        check("mid_accept_ready", 16'(load_ready), 16'd0);
        value_in   = 16'hFFFF;
        load_valid = 1'b1;
        adv_chk(16'h12AF);
        load_valid = 1'b0;
        value_in   = 16'h0000;
        check("ignored_ready", 16'(load_ready), 16'd0);
        repeat (8) adv_chk(16'h12AF);
        check("pre_boundary_ready", 16'(load_ready), 16'd0);
        adv_chk(16'h3456);
        check("commit_seg0", 16'(seg), 16'h0082);
        check("post_commit_ready", 16'(load_ready), 16'd1);
        repeat (31) adv_chk(16'h3456);

        // Accept on the exact boundary edge: commit one frame later.
        value_in   = 16'h7890;
        load_valid = 1'b1;
        adv_chk(16'h3456);
        load_valid = 1'b0;
        value_in   = 16'h0000;
        check("bnd_accept_ready", 16'(load_ready), 16'd0);
        repeat (15) adv_chk(16'h3456);
        check("bnd_wait_ready", 16'(load_ready), 16'd0);
        adv_chk(16'h7890);
        check("bnd_commit_ready", 16'(load_ready), 16'd1);

        // Async reset mid-slot with a value pending.
        value_in   = 16'h1111;
        load_valid = 1'b1;
        adv_chk(16'h7890);
        load_valid = 1'b0;
        value_in   = 16'h0000;
        check("rst_pending_ready", 16'(load_ready), 16'd0);
        adv_chk(16'h7890);
        #2 reset = 1'b1;
        #1;
        check("async_seg", 16'(seg), 16'h00FF);
        check("async_anode", 16'(anode), 16'h000F);
        check("async_fd", 16'(frame_done), 16'd0);
        check("async_ready", 16'(load_ready), 16'd1);
        step();
        check("held_anode", 16'(anode), 16'h000F);
        reset = 1'b0;

        // Pending value was discarded: display restarts on 0000.
        step();
        c = 0;
        check("rs_anode", 16'(anode), 16'h000E);
        check("rs_seg", 16'(seg), 16'(exp_seg(16'h0000, 0)));
        check("rs_fd", 16'(frame_done), 16'd0);
        repeat (31) adv_chk(16'h0000);

        // Disable on the boundary-ending cycle: blank, no frame_done.
        enable = 1'b0;
        step();
        check("dis_anode", 16'(anode), 16'h000F);
        check("dis_seg", 16'(seg), 16'h00FF);
        check("dis_fd", 16'(frame_done), 16'd0);
        repeat (20) begin
            step();
            check("dis_idle_fd", 16'(frame_done), 16'd0);
            check("dis_idle_anode", 16'(anode), 16'h000F);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
